// File: rtl/ame_num_compare.sv
// rtl/ame_num_compare.sv - 3-stage pipelined 6-input unsigned min/argmin finder
// Ties resolve to the lower candidate index at every stage.
module ame_num_compare #(
    parameter int COMP_DATA_BITS     = 64,
    parameter int COMP_DATA_IDX_BITS = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic                                comp_init_i,
    input  logic [5:0][COMP_DATA_BITS-1:0]      comp_data_i,
    output logic                                comp_done_o,
    output logic [COMP_DATA_BITS-1:0]           comp_data_o,
    output logic [COMP_DATA_IDX_BITS-1:0]       comp_data_idx_o
);

    typedef logic [COMP_DATA_BITS-1:0]     data_t;
    typedef logic [COMP_DATA_IDX_BITS-1:0] idx_t;

    // stage 1 registers
    data_t a_q, b_q, c_q;
    idx_t  a_idx_q, b_idx_q, c_idx_q;
    logic  v1_q;
    // stage 2 registers
    data_t d_q, c2_q;
    idx_t  d_idx_q, c2_idx_q;
    logic  v2_q;
    // stage 3 registers
    data_t out_q;
    idx_t  out_idx_q;
    logic  done_q;

    data_t a_d, b_d, c_d, d_d, out_d;
    idx_t  a_idx_d, b_idx_d, c_idx_d, d_idx_d, out_idx_d;

    // Strict less-than keeps the left (lower-index) operand on equality.
    always_comb begin
        a_d     = comp_data_i[0];
        a_idx_d = idx_t'(0);
        if (comp_data_i[1] < comp_data_i[0]) begin
            a_d     = comp_data_i[1];
            a_idx_d = idx_t'(1);
        end
        b_d     = comp_data_i[2];
        b_idx_d = idx_t'(2);
        if (comp_data_i[3] < comp_data_i[2]) begin
            b_d     = comp_data_i[3];
            b_idx_d = idx_t'(3);
        end
        c_d     = comp_data_i[4];
        c_idx_d = idx_t'(4);
        if (comp_data_i[5] < comp_data_i[4]) begin
            c_d     = comp_data_i[5];
            c_idx_d = idx_t'(5);
        end
        d_d     = a_q;
        d_idx_d = a_idx_q;
        if (b_q < a_q) begin
            d_d     = b_q;
            d_idx_d = b_idx_q;
        end
        out_d     = d_q;
        out_idx_d = d_idx_q;
        if (c2_q < d_q) begin
            out_d     = c2_q;
            out_idx_d = c2_idx_q;
        end
    end

    // Data registers load every cycle; only the valid bits qualify them.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            a_idx_q   <= '0;
            b_idx_q   <= '0;
            c_idx_q   <= '0;
            v1_q      <= 1'b0;
            d_q       <= '0;
            c2_q      <= '0;
            d_idx_q   <= '0;
            c2_idx_q  <= '0;
            v2_q      <= 1'b0;
            out_q     <= '0;
            out_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            a_idx_q   <= a_idx_d;
            b_idx_q   <= b_idx_d;
            c_idx_q   <= c_idx_d;
            v1_q      <= comp_init_i;
            d_q       <= d_d;
            c2_q      <= c_q;
            d_idx_q   <= d_idx_d;
            c2_idx_q  <= c_idx_q;
            v2_q      <= v1_q;
            out_q     <= out_d;
            out_idx_q <= out_idx_d;
            done_q    <= v2_q;
        end
    end

    assign comp_done_o     = done_q;
    assign comp_data_o     = out_q;
    assign comp_data_idx_o = out_idx_q;

endmodule

// File: tb/tb_ame_num_compare.sv
// tb/tb_ame_num_compare.sv - table and scoreboard bench for ame_num_compare
module tb_ame_num_compare;

    typedef logic [5:0][63:0] set_t;
    typedef struct {
        logic [63:0] d;
        logic [2:0]  k;
    } exp_t;
    typedef struct {
        set_t        d;
        logic [63:0] ed;
        logic [2:0]  ek;
    } vec_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        comp_init_i = 1'b0;
    set_t        comp_data_i = '0;
    logic        comp_done_o;
    logic [63:0] comp_data_o;
    logic [2:0]  comp_data_idx_o;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t sb[$];
    logic mv1 = 0, mv2 = 0, mv3 = 0;

    ame_num_compare #(.COMP_DATA_BITS(64), .COMP_DATA_IDX_BITS(3)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .comp_init_i(comp_init_i),
        .comp_data_i(comp_data_i), .comp_done_o(comp_done_o),
        .comp_data_o(comp_data_o), .comp_data_idx_o(comp_data_idx_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t ref_min(input set_t d);
        exp_t e;
        e.d = d[0];
        e.k = 3'd0;
        for (int i = 1; i < 6; i++)
            if (d[i] < e.d) begin
                e.d = d[i];
                e.k = 3'(i);
            end
        return e;
    endfunction

    // Latency model of the valid flag: three rising edges from drive to done.
    always @(posedge clk_i) begin
        if (!rst_n_i) begin
            mv1 = 0; mv2 = 0; mv3 = 0;
        end else begin
            mv3 = mv2; mv2 = mv1; mv1 = comp_init_i;
        end
    end

    always @(negedge clk_i) begin
        if (!rst_n_i) begin
            sb.delete();
            chk("rst_done", 64'(comp_done_o), 64'd0);
            chk("rst_data", comp_data_o, 64'd0);
            chk("rst_idx", 64'(comp_data_idx_o), 64'd0);
        end else begin
            chk("done_timing", 64'(comp_done_o), 64'(mv3));
            if (comp_done_o) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(sb.size()), 64'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("min_data", comp_data_o, e.d);
                    chk("min_idx", 64'(comp_data_idx_o), 64'(e.k));
                end
            end
        end
    end

    task automatic send(input set_t d, input logic v, input logic [63:0] ed, input logic [2:0] ek);
        exp_t e;
        @(posedge clk_i);
        #1;
        comp_data_i = d;
        comp_init_i = v;
        if (v) begin
            e.d = ed;
            e.k = ek;
            sb.push_back(e);
        end
    endtask

    task automatic send_rand(input logic v);
        set_t d;
        exp_t e;
        for (int i = 0; i < 6; i++)
            d[i] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
        e = ref_min(d);
        send(d, v, e.d, e.k);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send('0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[6];
        set_t d;
        logic [4:0] gap;

        tbl[0].d = '0;
        tbl[0].d[5] = 64'd9; tbl[0].d[4] = 64'd3; tbl[0].d[3] = 64'd7;
        tbl[0].d[2] = 64'd1; tbl[0].d[1] = 64'd8; tbl[0].d[0] = 64'd4;
        tbl[0].ed = 64'd1; tbl[0].ek = 3'd2;
        tbl[1].d = {6{64'hFFFF_FFFF_FFFF_FFFF}};
        tbl[1].ed = 64'hFFFF_FFFF_FFFF_FFFF; tbl[1].ek = 3'd0;
        tbl[2].d = {6{64'd10}};
        tbl[2].d[1] = 64'd0; tbl[2].d[4] = 64'd0;
        tbl[2].ed = 64'd0; tbl[2].ek = 3'd1;
        tbl[3].d = {6{64'd10}};
        tbl[3].d[5] = 64'd0;
        tbl[3].ed = 64'd0; tbl[3].ek = 3'd5;
        for (int i = 0; i < 6; i++) tbl[4].d[i] = 64'h8000_0000_0000_0000 + 64'(i);
        tbl[4].d[3] = 64'd0;
        tbl[4].ed = 64'd0; tbl[4].ek = 3'd3;
        tbl[5].d = {6{64'hFFFF_FFFF_FFFF_FFFF}};
        tbl[5].d[4] = 64'h7FFF_FFFF_FFFF_FFFF; tbl[5].d[2] = 64'h8000_0000_0000_0000;
        tbl[5].ed = 64'h7FFF_FFFF_FFFF_FFFF; tbl[5].ek = 3'd4;

        // reset held with live valid inputs
        rst_n_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i); #1;
            for (int j = 0; j < 6; j++) comp_data_i[j] = {$urandom, $urandom};
            comp_init_i = 1'b1;
        end
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        comp_init_i = 1'b0;
        idle(3);

        // single isolated set
        send(tbl[0].d, 1'b1, tbl[0].ed, tbl[0].ek);
        idle(5);

        // table vectors back to back
        for (int i = 0; i < 6; i++) send(tbl[i].d, 1'b1, tbl[i].ed, tbl[i].ek);
        idle(5);

        // 64-set continuous stream
        for (int i = 0; i < 64; i++) send_rand(1'b1);
        idle(5);

        // gapped valid 1,0,1,1,0
        gap = 5'b01101;
        for (int i = 0; i < 5; i++) send_rand(gap[i]);
        idle(5);

        // reset asserted mid-stream while done is high
        for (int i = 0; i < 5; i++) send_rand(1'b1);
        #2;
        chk("pre_rst_done", 64'(comp_done_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        chk("async_rst_done", 64'(comp_done_o), 64'd0);
        chk("async_rst_data", comp_data_o, 64'd0);
        chk("async_rst_idx", 64'(comp_data_idx_o), 64'd0);
        @(posedge clk_i); #1;
        comp_init_i = 1'b0;
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(6);

        // a few random gapped sets after recovery
        for (int i = 0; i < 20; i++) send_rand(1'($urandom_range(0, 1)));
        idle(6);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ame_num_compare.md
Name: ame_num_compare

Overview:
- Fully pipelined 6-input unsigned minimum finder for the AME (affine motion estimation) datapath.
- Each cycle it accepts six candidate cost values and outputs the smallest value plus its index 0..5.
- Used to select the best candidate among motion-search results.
- Streaming: one new input set per clock, fixed latency, a valid flag travels alongside the data.

Parameters:
- COMP_DATA_BITS, 64, width of each unsigned input value and of the output value.
- COMP_DATA_IDX_BITS, 3, width of the winning-index output; must be at least 3 to encode 0..5.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_n_i  input  1  reset; asynchronous, active-low.
- comp_init_i  input  1  input-valid; high marks comp_data_i as a valid set this cycle.
- comp_done_o  output  1  output-valid; comp_init_i delayed exactly 3 cycles.
- comp_data_i  input  6 x COMP_DATA_BITS  packed array [5:0][COMP_DATA_BITS-1:0]; element k is candidate k.
- comp_data_o  output  COMP_DATA_BITS  minimum of the six candidates.
- comp_data_idx_o  output  COMP_DATA_IDX_BITS  index k (0..5) of the minimum candidate.

Behaviour:
- Reset (rst_n_i=0, asynchronous): every pipeline register clears immediately.
  - comp_done_o=0, comp_data_o=0, comp_data_idx_o=0.
  - Reset mid-operation discards all in-flight sets; none produces a done pulse.
- Comparison rules:
  - Unsigned magnitude compare.
  - Tie: the lower index wins, so all-equal inputs give index 0.
- Stage 1 (registered), three pairwise minima with their indices:
  - A = min(d0,d1)
  - B = min(d2,d3)
  - C = min(d4,d5)
  - valid v1 <= comp_init_i.
- Stage 2 (registered):
  - D = min(A,B), tie goes to A.
  - C is forwarded unchanged with its index.
  - v2 <= v1.
- Stage 3 (registered outputs):
  - comp_data_o/comp_data_idx_o = min(D,C), tie goes to D.
  - comp_done_o <= v2.
- Latency and throughput:
  - Data sampled at edge N appears on the outputs after edge N+2, i.e. valid during the cycle following the third edge.
  - comp_done_o asserts for the same cycles.
  - Throughput is one set per cycle; back-to-back valid sets produce back-to-back done pulses with no bubbles.
- No handshake or backpressure: the data registers load every cycle regardless of valid, and comp_done_o qualifies them.
  - Output values while comp_done_o=0 are don't-care for checking, but they are deterministic.
- No internal state other than the pipeline; comp_init_i toggling at any rate is legal.
- Index encoding: zero-extended to COMP_DATA_IDX_BITS.

Test Plan:
- Reset check: hold rst_n_i=0 with random inputs and comp_init_i=1 -> all outputs 0. Assert reset mid-stream -> comp_done_o drops to 0 asynchronously, and no pulse is produced for flushed sets.
- Single set: d={5:9,4:3,3:7,2:1,1:8,0:4}, comp_init_i high for 1 cycle -> 3 cycles later comp_done_o=1 for 1 cycle, comp_data_o=1, comp_data_idx_o=2.
- Ties: all six = 64'hFFFF_FFFF_FFFF_FFFF -> data=all-ones, idx=0. d1=d4=0, others 10 -> idx=1. Min only at d5=0 -> idx=5.
- Width extremes: d3=0, others 64'h8000_0000_0000_0000 and above -> idx=3, data=0. This confirms unsigned compare with no sign interpretation of bit 63.
- Streaming: 64 consecutive random sets with comp_init_i held high -> 64 consecutive done cycles. Each output matches a reference min/argmin (lowest index on tie) of the set sent 3 cycles earlier.
- Gapped valid: comp_init_i pattern 1,0,1,1,0 -> comp_done_o shows the same pattern delayed by 3 cycles.
